// File: rtl/m32b_8b.sv
// Word-to-byte serializer: 32-bit words enter through a valid/ready handshake,
// are buffered in a small FIFO and leave as four consecutive bytes on clk_4f.
module m32b_8b #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic [7:0]  IDLE_DATA  = 8'h00
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_in,
  output logic [7:0]  data_out,
  output logic        valid_out
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_nxt;
  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [31:0]      cur_word, cur_word_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt;
  logic             push, pop;

  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] k);
    logic [1:0] sel;
    logic [7:0] b;
    sel = MSB_FIRST ? (2'd3 - k) : k;
    case (sel)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  always_comb begin
    push         = valid_in && ready_in;
    pop          = 1'b0;
    state_nxt    = state;
    idx_nxt      = idx;
    cur_word_nxt = cur_word;
    data_nxt     = IDLE_DATA;
    valid_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop          = 1'b1;
          state_nxt    = SEND;
          idx_nxt      = '0;
          cur_word_nxt = mem[rd_ptr];
          data_nxt     = pick(mem[rd_ptr], 2'd0);
          valid_nxt    = 1'b1;
        end
      end
      SEND: begin
        if (idx != 2'd3) begin
          idx_nxt   = idx + 2'd1;
          data_nxt  = pick(cur_word, idx + 2'd1);
          valid_nxt = 1'b1;
        end else if (count != '0) begin
          // Last byte out: chain straight into the next word without a gap
          pop          = 1'b1;
          idx_nxt      = '0;
          cur_word_nxt = mem[rd_ptr];
          data_nxt     = pick(mem[rd_ptr], 2'd0);
          valid_nxt    = 1'b1;
        end else begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_4f) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cur_word  <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ready_in  <= 1'b0;
      data_out  <= IDLE_DATA;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cur_word  <= cur_word_nxt;
      count     <= count_nxt;
      ready_in  <= count_nxt < DEPTH_C;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      if (push) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_m32b_8b.sv
// Bench for m32b_8b: directed and random words against a schedule-based model
// (each word owns four consecutive byte slots starting after its accept edge).
module tb_m32b_8b;

  localparam int unsigned DEPTH = 2;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_m, ready_l;
  logic [7:0]  data_m, data_l;
  logic        valid_m, valid_l;

  m32b_8b dut_msb (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_m), .data_out(data_m), .valid_out(valid_m));

  m32b_8b #(.FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0), .IDLE_DATA(8'hA5)) dut_lsb (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_l), .data_out(data_l), .valid_out(valid_l));

  always #5 clk_4f = ~clk_4f;

  typedef struct {int start; logic [31:0] w;} ent_t;
  ent_t q[$];
  int   cyc = 0;
  int   last_start = -100;
  bit   exp_ready = 1'b0;
  bit   acc = 1'b0;
  int   acc_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    q.delete();
    last_start = -100;
    exp_ready  = 1'b0;
  endtask

  task automatic model_edge();
    int occ;
    int st;
    cyc++;
    acc = 1'b0;
    if (reset) begin
      model_clear();
    end else begin
      if (valid_in && exp_ready) begin
        st = cyc + 1;
        if (last_start + 4 > st) st = last_start + 4;
        q.push_back('{start: st, w: data_in});
        last_start = st;
        acc = 1'b1;
        acc_cyc = cyc;
      end
      occ = 0;
      foreach (q[i]) if (q[i].start > cyc) occ++;
      exp_ready = (occ < DEPTH);
      while (q.size() > 0 && q[0].start + 3 < cyc) void'(q.pop_front());
    end
  endtask

  task automatic check_all();
    logic       ev;
    logic [7:0] em, el;
    int         k;
    ev = 1'b0;
    em = 8'h00;
    el = 8'hA5;
    if (q.size() > 0 && q[0].start <= cyc && cyc <= q[0].start + 3) begin
      k  = cyc - q[0].start;
      ev = 1'b1;
      em = 8'(q[0].w >> (24 - 8 * k));
      el = 8'(q[0].w >> (8 * k));
    end
    chk("ready_msb", {31'b0, ready_m}, {31'b0, exp_ready});
    chk("valid_msb", {31'b0, valid_m}, {31'b0, ev});
    chk("data_msb",  {24'b0, data_m},  {24'b0, em});
    chk("ready_lsb", {31'b0, ready_l}, {31'b0, exp_ready});
    chk("valid_lsb", {31'b0, valid_l}, {31'b0, ev});
    chk("data_lsb",  {24'b0, data_l},  {24'b0, el});
  endtask

  task automatic tick();
    @(posedge clk_4f);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    data_in  = $urandom;
    for (int i = 0; i < n; i++) tick();
  endtask

  // valid_in stays high until the model sees the handshake; data is X while not ready
  task automatic send_word(input logic [31:0] w);
    int budget;
    budget   = 0;
    valid_in = 1'b1;
    acc      = 1'b0;
    while (!acc) begin
      data_in = exp_ready ? w : 'x;
      tick();
      budget++;
      if (!acc && budget > 20) begin
        checks++;
        errors++;
        $error("FAIL send_timeout observed=no_accept expected=accept word=%h", w);
        break;
      end
    end
  endtask

  task automatic async_reset();
    #3 reset = 1'b1;
    #1;
    model_clear();
    check_all();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    #2 reset = 1'b1;
    #1;
    check_all();
    tick();
    tick();
    reset = 1'b0;
    tick();
    idle(3);

    send_word(32'hFFDDAA00);
    idle(6);

    send_word(32'h01020304);
    n0 = acc_cyc;
    send_word(32'h05060708);
    chk("b2b_acc1", 32'(acc_cyc - n0), 32'd1);
    send_word(32'h090A0B0C);
    chk("b2b_acc2", 32'(acc_cyc - n0), 32'd2);
    send_word(32'h0D0E0F10);
    chk("b2b_acc3", 32'(acc_cyc - n0), 32'd6);
    idle(16);

    send_word(32'hAABBCCDD);
    idle(6);
    send_word(32'h00000003);
    idle(6);

    send_word(32'h11223344);
    idle(2);
    async_reset();
    send_word(32'h55667788);
    idle(6);

    for (int i = 0; i < 150; i++) begin
      int gap;
      gap = int'($urandom_range(0, 5));
      if (gap > 0 && gap < 4) idle(gap);
      send_word($urandom);
      if ($urandom_range(0, 39) == 0) async_reset();
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
